// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path encodings, state enum and default vectors
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_JR  = 2'b01,
    PC_BR  = 2'b10,
    PC_JMP = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRAP = 2'b01,
    ST_HALT = 2'b10
  } trap_state_e;

  localparam logic [31:0] DEF_RESET_VEC      = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC       = 32'h0000_0180;
  localparam logic [3:0]  DEF_MISALIGN_CAUSE = 4'h4;
  localparam logic [3:0]  CAUSE_NONE         = 4'h0;

  // Sequential fetch is always word aligned, so only redirects can misalign.
  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] lsb);
    return (sel != PC_SEQ) && (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_trap_ctl.sv
// rtl/pc_trap_ctl.sv - RUN/TRAP/HALT state machine with epc and cause capture
module pc_trap_ctl
  import cpu_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter logic [3:0]  MISALIGN_CAUSE = DEF_MISALIGN_CAUSE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            misalign,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic            eret,
  input  logic [XLEN-1:0] pc,
  output logic            trap_event,
  output logic            take_trap,
  output logic            do_eret,
  output logic [XLEN-1:0] epc,
  output logic [3:0]      cause,
  output logic            in_trap,
  output logic            halted
);

  trap_state_e state, state_nxt;

  // A stalled misaligned redirect is not a fault yet; it is re-checked once unstalled.
  assign trap_event = trap_req | (misalign & ~stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (trap_event) state_nxt = ST_TRAP;
      ST_TRAP: begin
        if (trap_event)          state_nxt = ST_HALT;
        else if (eret && !stall) state_nxt = ST_RUN;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    in_trap   = (state == ST_TRAP);
    halted    = (state == ST_HALT);
    take_trap = (state == ST_RUN) && trap_event;
    do_eret   = (state == ST_TRAP) && !trap_event && eret && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc   <= '0;
      cause <= CAUSE_NONE;
    end else if (take_trap) begin
      epc   <= pc;
      cause <= trap_req ? trap_cause : MISALIGN_CAUSE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC selection and PC register at the head of fetch
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VEC      = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC       = XLEN'(DEF_TRAP_VEC),
  parameter logic [3:0]      MISALIGN_CAUSE = DEF_MISALIGN_CAUSE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] branch_addr,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic            eret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic [3:0]      cause,
  output logic            in_trap,
  output logic            halted
);

  logic [XLEN-1:0] target;
  logic            misalign;
  logic            trap_event;
  logic            take_trap;
  logic            do_eret;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    target = pc_plus4;
    case (pc_sel)
      PC_SEQ:  target = pc_plus4;
      PC_JR:   target = rs_data;
      PC_BR:   target = branch_addr;
      PC_JMP:  target = jump_addr;
      default: target = pc_plus4;
    endcase
  end

  assign misalign = is_misaligned(pc_sel, target[1:0]);

  pc_trap_ctl #(
    .XLEN           (XLEN),
    .MISALIGN_CAUSE (MISALIGN_CAUSE)
  ) u_trap_ctl (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .misalign   (misalign),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .eret       (eret),
    .pc         (pc),
    .trap_event (trap_event),
    .take_trap  (take_trap),
    .do_eret    (do_eret),
    .epc        (epc),
    .cause      (cause),
    .in_trap    (in_trap),
    .halted     (halted)
  );

  // A trap event seen while already in TRAP is the double fault: PC freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      pc <= RESET_VEC;
    else if (halted)                 pc <= pc;
    else if (take_trap)              pc <= TRAP_VEC;
    else if (trap_event)             pc <= pc;
    else if (do_eret)                pc <= epc;
    else if (!stall)                 pc <= target;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] rs_data = '0, branch_addr = '0, jump_addr = '0;
  logic        trap_req = 1'b0;
  logic [3:0]  trap_cause = '0;
  logic        eret = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic [3:0]  cause;
  logic        in_trap, halted;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference state: 0 running, 1 in handler, 2 halted
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_cause;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel),
    .rs_data(rs_data), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .trap_req(trap_req), .trap_cause(trap_cause), .eret(eret),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .cause(cause),
    .in_trap(in_trap), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_addr(input logic [31:0] cur, input logic [1:0] sel,
                                            input logic [31:0] r, input logic [31:0] b,
                                            input logic [31:0] j);
    case (sel)
      2'd0:    return cur + 32'd4;
      2'd1:    return r;
      2'd2:    return b;
      default: return j;
    endcase
  endfunction

  // Reference model: applies the first matching rule for this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_pc    <= 32'h0;
      m_epc   <= 32'h0;
      m_cause <= 4'h0;
    end else begin
      logic [31:0] dest;
      bit bad, fault;
      dest  = next_addr(m_pc, pc_sel, rs_data, branch_addr, jump_addr);
      bad   = (pc_sel != 2'd0) && (dest % 4 != 0);
      fault = trap_req || (bad && !stall);
      if (m_mode == 2) begin
      end else if (fault) begin
        if (m_mode == 0) begin
          m_epc   <= m_pc;
          m_cause <= trap_req ? trap_cause : 4'h4;
          m_pc    <= 32'h180;
          m_mode  <= 1;
        end else begin
          m_mode  <= 2;
        end
      end else if (m_mode == 1 && eret && !stall) begin
        m_pc   <= m_epc;
        m_mode <= 0;
      end else if (!stall) begin
        m_pc <= dest;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("epc", epc, m_epc);
      chk("cause", {28'h0, cause}, {28'h0, m_cause});
      chk("in_trap", {31'h0, in_trap}, {31'h0, m_mode == 1});
      chk("halted", {31'h0, halted}, {31'h0, m_mode == 2});
    end
  end

  task automatic drive(input logic [1:0] sel, input logic [31:0] addr,
                       input logic st, input logic tr, input logic [3:0] tc, input logic er);
    pc_sel = sel; rs_data = addr; branch_addr = addr; jump_addr = addr;
    stall = st; trap_req = tr; trap_cause = tc; eret = er;
    @(negedge clk);
  endtask

  initial begin
    int halt_cnt;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {28'h0, cause}, 32'h0);
    rst_n = 1'b1;

    drive(2'd0, 0, 0, 0, 0, 0); chk("seq1", pc, 32'h4);
    drive(2'd0, 0, 0, 0, 0, 0); chk("seq2", pc, 32'h8);
    drive(2'd0, 0, 0, 0, 0, 0); chk("seq3", pc, 32'hC);
    chk("plus4", pc_plus4, 32'h10);
    drive(2'd1, 32'h100, 0, 0, 0, 0); chk("jr", pc, 32'h100);
    drive(2'd2, 32'h200, 0, 0, 0, 0); chk("br", pc, 32'h200);
    drive(2'd3, 32'h300, 0, 0, 0, 0); chk("jmp", pc, 32'h300);
    drive(2'd3, 32'hFFFF_FFFC, 0, 0, 0, 0);
    drive(2'd0, 0, 0, 0, 0, 0); chk("wrap", pc, 32'h0);

    drive(2'd3, 32'h40, 0, 0, 0, 0);
    drive(2'd0, 0, 1, 0, 0, 0); chk("stall1", pc, 32'h40);
    drive(2'd0, 0, 1, 0, 0, 0); chk("stall2", pc, 32'h40);
    drive(2'd0, 0, 1, 1, 4'h3, 0); chk("stall_trap", pc, 32'h180);
    drive(2'd0, 0, 0, 0, 0, 1); chk("eret_stall_trap", pc, 32'h40);

    drive(2'd3, 32'h20, 0, 0, 0, 0);
    drive(2'd0, 0, 0, 1, 4'h8, 0);
    chk("trap_pc", pc, 32'h180);
    chk("trap_epc", epc, 32'h20);
    chk("trap_cause", {28'h0, cause}, 32'h8);
    chk("trap_in", {31'h0, in_trap}, 32'h1);
    drive(2'd0, 0, 0, 0, 0, 0); chk("handler_seq", pc, 32'h184);
    drive(2'd0, 0, 0, 0, 0, 1);
    chk("eret_pc", pc, 32'h20);
    chk("eret_in", {31'h0, in_trap}, 32'h0);

    drive(2'd3, 32'h10, 0, 0, 0, 0);
    drive(2'd2, 32'h102, 1, 0, 0, 0);
    chk("mis_stall_pc", pc, 32'h10);
    chk("mis_stall_in", {31'h0, in_trap}, 32'h0);
    drive(2'd2, 32'h102, 0, 0, 0, 0);
    chk("mis_pc", pc, 32'h180);
    chk("mis_epc", epc, 32'h10);
    chk("mis_cause", {28'h0, cause}, 32'h4);

    drive(2'd0, 0, 0, 1, 4'h2, 0);
    chk("dbl_halt", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, 32'h500, 0, 0, 0, 1);
      chk("halt_frozen", pc, 32'h180);
    end

    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      pc_sel      = 2'($urandom_range(0, 3));
      rs_data     = a;
      branch_addr = {a[15:0], a[31:16]} & ~32'h3 | ($urandom_range(0, 9) == 0 ? 32'h2 : 32'h0);
      jump_addr   = a ^ 32'h0000_1000;
      stall       = ($urandom_range(0, 5) == 0);
      trap_req    = ($urandom_range(0, 15) == 0);
      trap_cause  = 4'($urandom);
      eret        = ($urandom_range(0, 6) == 0);
      halt_cnt    = halted ? halt_cnt + 1 : 0;
      rst_n       = (halt_cnt < 6);
      if (!rst_n) halt_cnt = 0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator, the successor to the single-cycle PC register. It selects the next fetch address from sequential, register-indirect, branch and jump sources. It adds a fetch stall, a trap path with exception-PC and cause capture, a return-from-trap path, misaligned-target detection and a double-fault halt state. It sits at the head of the fetch path and drives the instruction-memory address and the PC+4 value used by link and branch logic.

## Interface
- `XLEN`, 32: address width.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `TRAP_VEC`, 32'h0000_0180: handler entry address.
- `MISALIGN_CAUSE`, 4'h4: cause code recorded for a misaligned target.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold PC and all state this cycle.
- `pc_sel`  in  2  00 seq (PC+4), 01 jr (`rs_data`), 10 branch (`branch_addr`), 11 jump (`jump_addr`).
- `rs_data`  in  XLEN  jr target.
- `branch_addr`  in  XLEN  branch target.
- `jump_addr`  in  XLEN  j/jal target.
- `trap_req`  in  1  external/decoder trap request, single-cycle pulse.
- `trap_cause`  in  4  cause code, valid with `trap_req`.
- `eret`  in  1  return from trap.
- `pc`  out  XLEN  current fetch address, registered.
- `pc_plus4`  out  XLEN  `pc`+4, combinational, wraps modulo 2^XLEN.
- `epc`  out  XLEN  PC of the trapping instruction, registered.
- `cause`  out  4  last trap cause, registered.
- `in_trap`  out  1  high while in the TRAP state.
- `halted`  out  1  high in the HALT state.

## Operation
States:
- RUN: normal execution.
- TRAP: handler executing.
- HALT: double fault; PC frozen.

Reset values: `pc`=RESET_VEC, `epc`=0, `cause`=0, state RUN (`in_trap`=0, `halted`=0).

Target selection and misalignment:
- `target` is the source chosen by `pc_sel`.
- `misalign` = (`pc_sel`≠00) and `target[1:0]`≠0.

Each rising edge, the first matching rule below applies:
1. State HALT: nothing changes. Only reset leaves HALT.
2. A trap event is `trap_req`, or `misalign` when `stall`=0.
   - In RUN: `epc`←`pc`; `cause`←`trap_cause` if `trap_req`, else MISALIGN_CAUSE. `trap_req` wins when both are present. `pc`←TRAP_VEC; go to TRAP.
   - In TRAP: go to HALT. `pc`, `epc` and `cause` are unchanged.
   - A trap event overrides `stall`.
3. `eret` in TRAP with `stall`=0: `pc`←`epc`; go to RUN.
   - `eret` in RUN is ignored: PC takes the normal update and `eret` has no effect.
4. `stall`=1: hold everything.
5. Otherwise: `pc`←`target`.

Other rules:
- PC+4 wraps: `pc`=32'hFFFF_FFFC with seq gives 0.
- `eret` asserted together with `trap_req` in TRAP counts as a double fault and goes to HALT.
- When `stall` and `misalign` coincide, no trap is taken. The PC holds, and the misalignment is re-evaluated on the next unstalled cycle.
- Asserting `rst_n` mid-operation immediately forces the reset values, regardless of state.

## Timing
- Every output except `pc_plus4` is a register updated at the rising edge. There are no combinational paths from inputs to outputs.
- The next-PC source is applied in the same edge. There is one cycle from a `pc_sel`/`trap_req`/`eret` sample to the new `pc`.
- `in_trap` and `halted` are decoded directly from the state register, with no extra delay.
- `epc` and `cause` change only on a trap taken from RUN.

## Structure
- Shared package `cpu_pkg`, containing:
  - the `pc_sel` encodings (SEQ/JR/BR/JMP);
  - the state enum (RUN/TRAP/HALT);
  - the default vectors and cause constants.
- Optional sub-module `pc_trap_ctl`, holding the state FSM plus the `epc`/`cause` registers. The PC mux and PC register stay in `pc_gen`.

## Test plan
- Reset and sequential fetch:
  - hold `rst_n`=0 → `pc`=0, `epc`=0, `cause`=0;
  - release with `pc_sel`=00 for 3 edges → `pc` = 4, 8, 12;
  - `pc_plus4`=16.
- Sources and wrap:
  - `pc_sel`=01 with `rs_data`=32'h100 → `pc`=32'h100;
  - 10 with 32'h200 → 32'h200;
  - 11 with 32'h300 → 32'h300;
  - force `pc`=32'hFFFF_FFFC, then seq → `pc`=0.
- Stall:
  - `stall`=1 for 2 cycles at `pc`=32'h40 → `pc` stays 32'h40;
  - `stall`=1 together with `trap_req` → trap taken, `pc`=32'h180.
- Trap and return:
  - at `pc`=32'h20, `trap_req` with cause 4'h8 → `pc`=32'h180, `epc`=32'h20, `cause`=8, `in_trap`=1;
  - later `eret` → `pc`=32'h20, `in_trap`=0.
- Misalignment:
  - `pc_sel`=10 with `branch_addr`=32'h102 at `pc`=32'h10 → `pc`=32'h180, `epc`=32'h10, `cause`=4;
  - the same with `stall`=1 → `pc` holds 32'h10, no trap.
- Double fault and reset:
  - `trap_req` while `in_trap`=1 → `halted`=1 and `pc` frozen for 5 cycles, ignoring `eret`;
  - asynchronous `rst_n` low mid-cycle → immediately `pc`=0 and `halted`=0.
